// File: rtl/oflow_conflict_resolve_fsm.sv
// Scans the score board, claims each entry's ID in the LUT and settles ID clashes by score,
// pushing the loser to its next fallback candidate and rescanning until a pass is clean.
module oflow_conflict_resolve_fsm #(
  parameter int unsigned MAX_CONFLICTS_TH = 64,
  parameter int unsigned NUM_ROWS         = 32,
  parameter int unsigned NUM_PES          = 24
) (
  input  logic        clk,
  input  logic        reset_N,
  input  logic        start_cr,
  output logic        done_cr,
  input  logic [15:0] data_out_lut_for_fsm,
  output logic [10:0] address_lut,
  output logic [15:0] data_in_lut,
  output logic        we_lut,
  output logic        csb,
  input  logic        data_out_flag,
  output logic [10:0] address_flag,
  output logic        data_in_flag,
  input  logic [9:0]  score_to_cr,
  input  logic [10:0] id_to_cr,
  output logic [4:0]  row_sel,
  output logic [4:0]  pe_sel,
  output logic [4:0]  row_to_change,
  output logic [4:0]  pe_to_change,
  output logic        data_to_score_board,
  output logic        write_to_pointer,
  output logic        conflict_counter_th
);

  localparam int unsigned ROW_LEN   = 5;
  localparam int unsigned PE_LEN    = 5;
  localparam int unsigned SCORE_LEN = 10;
  localparam int unsigned ID_LEN    = 11;
  localparam int unsigned CNT_W     = $clog2(MAX_CONFLICTS_TH + 1);

  localparam logic [ROW_LEN-1:0] ROW_LAST = ROW_LEN'(NUM_ROWS - 1);
  localparam logic [PE_LEN-1:0]  PE_LAST  = PE_LEN'(NUM_PES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_CONFLICTS_TH);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCheck,
    StCompare,
    StNext,
    StDone
  } state_t;

  state_t               state_q;
  logic [ROW_LEN-1:0]   row_q;
  logic [PE_LEN-1:0]    pe_q;
  logic [ROW_LEN-1:0]   own_row_q;
  logic [PE_LEN-1:0]    own_pe_q;
  logic [SCORE_LEN-1:0] score_q;
  logic [ID_LEN-1:0]    id_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 pass_conflict_q;
  logic                 th_q;

  logic [ROW_LEN-1:0] lut_row;
  logic [PE_LEN-1:0]  lut_pe;
  logic [15:0]        cur_word;
  logic               owner_is_cur;
  logic               cur_wins;
  logic [CNT_W-1:0]   cnt_inc;
  logic               th_hit;
  logic               unused_lut_bits;

  assign lut_row         = data_out_lut_for_fsm[10:6];
  assign lut_pe          = data_out_lut_for_fsm[5:1];
  assign unused_lut_bits = ^{data_out_lut_for_fsm[15:11], data_out_lut_for_fsm[0]};
  assign cur_word        = {5'b0, row_q, pe_q, 1'b0};
  assign owner_is_cur    = (lut_row == row_q) && (lut_pe == pe_q);
  // Strictly lower score takes the ID; on a tie the existing owner keeps it.
  assign cur_wins        = score_q < score_to_cr;
  assign cnt_inc         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign th_hit          = cnt_inc == CNT_MAX;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q         <= StIdle;
      row_q           <= '0;
      pe_q            <= '0;
      own_row_q       <= '0;
      own_pe_q        <= '0;
      score_q         <= '0;
      id_q            <= '0;
      cnt_q           <= '0;
      pass_conflict_q <= 1'b0;
      th_q            <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_cr) begin
            state_q         <= StRead;
            row_q           <= '0;
            pe_q            <= '0;
            cnt_q           <= '0;
            pass_conflict_q <= 1'b0;
            th_q            <= 1'b0;
          end
        end
        StRead: begin
          score_q <= score_to_cr;
          id_q    <= id_to_cr;
          state_q <= (&score_to_cr) ? StNext : StCheck;
        end
        StCheck: begin
          if (!data_out_flag || owner_is_cur) begin
            state_q <= StNext;
          end else begin
            own_row_q <= lut_row;
            own_pe_q  <= lut_pe;
            state_q   <= StCompare;
          end
        end
        StCompare: begin
          cnt_q           <= cnt_inc;
          pass_conflict_q <= 1'b1;
          if (th_hit) begin
            th_q    <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= StNext;
          end
        end
        StNext: begin
          if (pe_q == PE_LAST) begin
            pe_q <= '0;
            if (row_q == ROW_LAST) begin
              // A pass that moved any pointer may have exposed new clashes: rescan.
              if (pass_conflict_q) begin
                row_q           <= '0;
                pass_conflict_q <= 1'b0;
                state_q         <= StRead;
              end else begin
                state_q <= StDone;
              end
            end else begin
              row_q   <= row_q + ROW_LEN'(1);
              state_q <= StRead;
            end
          end else begin
            pe_q    <= pe_q + PE_LEN'(1);
            state_q <= StRead;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory-side strobes are decoded from the state so the LUT read issued in READ
  // returns in CHECK, and the flag lookup sees the registered ID in the same cycle.
  always_comb begin
    done_cr             = 1'b0;
    address_lut         = '0;
    data_in_lut         = '0;
    we_lut              = 1'b0;
    csb                 = 1'b1;
    data_in_flag        = 1'b0;
    row_sel             = '0;
    pe_sel              = '0;
    row_to_change       = '0;
    pe_to_change        = '0;
    data_to_score_board = 1'b0;
    write_to_pointer    = 1'b0;
    unique case (state_q)
      StRead: begin
        row_sel     = row_q;
        pe_sel      = pe_q;
        address_lut = id_to_cr;
        csb         = 1'b0;
      end
      StCheck: begin
        row_sel     = row_q;
        pe_sel      = pe_q;
        address_lut = id_q;
        if (!data_out_flag) begin
          we_lut       = 1'b1;
          csb          = 1'b0;
          data_in_flag = 1'b1;
          data_in_lut  = cur_word;
        end
      end
      StCompare: begin
        row_sel             = own_row_q;
        pe_sel              = own_pe_q;
        address_lut         = id_q;
        write_to_pointer    = 1'b1;
        data_to_score_board = 1'b1;
        if (cur_wins) begin
          row_to_change = own_row_q;
          pe_to_change  = own_pe_q;
          we_lut        = 1'b1;
          csb           = 1'b0;
          data_in_flag  = 1'b1;
          data_in_lut   = cur_word;
        end else begin
          row_to_change = row_q;
          pe_to_change  = pe_q;
        end
      end
      StDone:  done_cr = 1'b1;
      default: ;
    endcase
  end

  assign address_flag        = address_lut;
  assign conflict_counter_th = th_q;

endmodule

// File: tb/tb_oflow_conflict_resolve_fsm.sv
// Bench for oflow_conflict_resolve_fsm: behavioural score board, LUT and flag memories around
// the DUT, with end-of-run results compared against a loop-level model of the resolution rules.
module tb_oflow_conflict_resolve_fsm;

  localparam int NR     = 32;
  localparam int NP     = 24;
  localparam int NE     = NR * NP;
  localparam int TH     = 2;
  localparam int BUDGET = 20000;
  localparam logic [64:0] RST_VEC = {2'b00, 1'b1, 62'b0};

  logic        clk = 1'b0;
  logic        reset_N;
  logic        start_cr;
  logic        done_cr;
  logic [15:0] data_out_lut_for_fsm;
  logic [10:0] address_lut;
  logic [15:0] data_in_lut;
  logic        we_lut;
  logic        csb;
  logic        data_out_flag;
  logic [10:0] address_flag;
  logic        data_in_flag;
  logic [9:0]  score_to_cr;
  logic [10:0] id_to_cr;
  logic [4:0]  row_sel;
  logic [4:0]  pe_sel;
  logic [4:0]  row_to_change;
  logic [4:0]  pe_to_change;
  logic        data_to_score_board;
  logic        write_to_pointer;
  logic        conflict_counter_th;

  int checks = 0;
  int errors = 0;

  oflow_conflict_resolve_fsm #(
    .MAX_CONFLICTS_TH(TH),
    .NUM_ROWS(NR),
    .NUM_PES(NP)
  ) dut (
    .clk(clk),
    .reset_N(reset_N),
    .start_cr(start_cr),
    .done_cr(done_cr),
    .data_out_lut_for_fsm(data_out_lut_for_fsm),
    .address_lut(address_lut),
    .data_in_lut(data_in_lut),
    .we_lut(we_lut),
    .csb(csb),
    .data_out_flag(data_out_flag),
    .address_flag(address_flag),
    .data_in_flag(data_in_flag),
    .score_to_cr(score_to_cr),
    .id_to_cr(id_to_cr),
    .row_sel(row_sel),
    .pe_sel(pe_sel),
    .row_to_change(row_to_change),
    .pe_to_change(pe_to_change),
    .data_to_score_board(data_to_score_board),
    .write_to_pointer(write_to_pointer),
    .conflict_counter_th(conflict_counter_th)
  );

  always #5 clk = ~clk;

  // Score board: per entry a list of (score, id) candidates and a fallback pointer.
  int unsigned n_cand [NE];
  logic [9:0]  c_score [NE][4];
  logic [10:0] c_id [NE][4];
  int unsigned ptr [NE];
  logic [15:0] lut_mem [2048];
  logic        flag_mem [2048];
  logic [15:0] lut_dout;
  int          lut_wr_cnt;
  int          ptr_wr_cnt;
  logic        env_clr = 1'b0;

  always_comb begin
    int unsigned e;
    e = int'(row_sel) * NP + int'(pe_sel);
    score_to_cr = 10'h3FF;
    id_to_cr    = '0;
    if (e < NE && ptr[e] < n_cand[e]) begin
      score_to_cr = c_score[e][ptr[e]];
      id_to_cr    = c_id[e][ptr[e]];
    end
    data_out_flag        = flag_mem[address_flag];
    data_out_lut_for_fsm = lut_dout;
  end

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 2048; i++) begin
        lut_mem[i]  <= '0;
        flag_mem[i] <= 1'b0;
      end
      for (int i = 0; i < NE; i++) ptr[i] <= 0;
      lut_dout   <= '0;
      lut_wr_cnt <= 0;
      ptr_wr_cnt <= 0;
    end else begin
      if (!csb) begin
        if (we_lut) begin
          lut_mem[address_lut] <= data_in_lut;
          lut_wr_cnt           <= lut_wr_cnt + 1;
        end else begin
          lut_dout <= lut_mem[address_lut];
        end
      end
      if (we_lut) flag_mem[address_flag] <= data_in_flag;
      if (write_to_pointer && data_to_score_board) begin
        ptr[int'(row_to_change) * NP + int'(pe_to_change)] <=
            ptr[int'(row_to_change) * NP + int'(pe_to_change)] + 1;
        ptr_wr_cnt <= ptr_wr_cnt + 1;
      end
    end
  end

  // Reference model state.
  int unsigned m_ptr [NE];
  int          m_lut [2048];
  bit          m_flag [2048];
  int          m_lutw;
  int          m_ptrw;
  int          m_conf;
  bit          m_th;

  function automatic logic [9:0] m_score(int e);
    return (m_ptr[e] < n_cand[e]) ? c_score[e][m_ptr[e]] : 10'h3FF;
  endfunction

  task automatic model_run();
    bit again;
    bit stop;
    for (int e = 0; e < NE; e++) m_ptr[e] = 0;
    for (int i = 0; i < 2048; i++) begin
      m_lut[i]  = 0;
      m_flag[i] = 1'b0;
    end
    m_lutw = 0;
    m_ptrw = 0;
    m_conf = 0;
    m_th   = 1'b0;
    stop   = 1'b0;
    do begin
      again = 1'b0;
      for (int e = 0; e < NE && !stop; e++) begin
        logic [9:0]  s;
        logic [10:0] id;
        int          o;
        s = m_score(e);
        if (s == 10'h3FF) continue;
        id = c_id[e][m_ptr[e]];
        if (!m_flag[id]) begin
          m_flag[id] = 1'b1;
          m_lut[id]  = e;
          m_lutw++;
        end else if (m_lut[id] != e) begin
          o = m_lut[id];
          if (s < m_score(o)) begin
            m_ptr[o]++;
            m_lut[id] = e;
            m_lutw++;
          end else begin
            m_ptr[e]++;
          end
          m_ptrw++;
          m_conf++;
          again = 1'b1;
          if (m_conf >= TH) begin
            m_th = 1'b1;
            stop = 1'b1;
          end
        end
      end
    end while (again && !stop);
  endtask

  function automatic logic [64:0] outs();
    return {done_cr, we_lut, csb, write_to_pointer, data_to_score_board, conflict_counter_th,
            data_in_flag, address_lut, address_flag, data_in_lut, row_sel, pe_sel,
            row_to_change, pe_to_change};
  endfunction

  task automatic clear_board();
    for (int e = 0; e < NE; e++) n_cand[e] = 0;
  endtask

  task automatic set_cand(int e, int k, int score, int id);
    c_score[e][k] = 10'(score);
    c_id[e][k]    = 11'(id);
    if (n_cand[e] < k + 1) n_cand[e] = k + 1;
  endtask

  task automatic env_clear();
    @(negedge clk);
    env_clr = 1'b1;
    @(negedge clk);
    env_clr = 1'b0;
  endtask

  // Runs one resolution and compares the memory-side results against the model.
  task automatic run_scenario(string name, bit glitch);
    int  cyc;
    bit  got;
    int  bad;
    int  first;
    logic [15:0] exp;
    model_run();
    @(negedge clk);
    start_cr = 1'b1;
    @(negedge clk);
    start_cr = 1'b0;
    checks++;
    if (conflict_counter_th !== 1'b0) begin
      errors++;
      $display("FAIL %s th_clear_on_start: got %b want 0", name, conflict_counter_th);
    end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < BUDGET) begin
      start_cr = glitch && (cyc == 10);
      if (done_cr) got = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    start_cr = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done_timeout: no done_cr within %0d cycles", name, BUDGET);
    end
    @(negedge clk);
    checks++;
    if (done_cr !== 1'b0) begin
      errors++;
      $display("FAIL %s done_one_cycle: got %b want 0", name, done_cr);
    end
    checks++;
    if (lut_wr_cnt !== m_lutw) begin
      errors++;
      $display("FAIL %s lut_writes: got %0d want %0d", name, lut_wr_cnt, m_lutw);
    end
    checks++;
    if (ptr_wr_cnt !== m_ptrw) begin
      errors++;
      $display("FAIL %s pointer_writes: got %0d want %0d", name, ptr_wr_cnt, m_ptrw);
    end
    checks++;
    if (conflict_counter_th !== logic'(m_th)) begin
      errors++;
      $display("FAIL %s conflict_th: got %b want %b", name, conflict_counter_th, m_th);
    end
    bad   = 0;
    first = -1;
    for (int id = 0; id < 2048; id++) begin
      exp = m_flag[id] ? {5'b0, 5'(m_lut[id] / NP), 5'(m_lut[id] % NP), 1'b0} : 16'h0;
      if (lut_mem[id] !== exp || flag_mem[id] !== logic'(m_flag[id])) begin
        bad++;
        if (first < 0) first = id;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s lut_contents: %0d bad ids, first %0d got %h/%b want %h/%b", name, bad,
               first, lut_mem[first], flag_mem[first], m_lut[first], m_flag[first]);
    end
    bad   = 0;
    first = -1;
    for (int e = 0; e < NE; e++) begin
      if (ptr[e] != m_ptr[e]) begin
        bad++;
        if (first < 0) first = e;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s board_pointers: %0d bad entries, first %0d got %0d want %0d", name, bad,
               first, ptr[first], m_ptr[first]);
    end
  endtask

  task automatic test_reset();
    reset_N  = 1'b0;
    start_cr = 1'b0;
    clear_board();
    env_clear();
    @(negedge clk);
    checks++;
    if (outs() !== RST_VEC) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", outs(), RST_VEC);
    end
    reset_N = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== RST_VEC) begin
      errors++;
      $display("FAIL idle_outputs: got %h want %h", outs(), RST_VEC);
    end
  endtask

  task automatic test_distinct();
    clear_board();
    for (int e = 0; e < NE; e++) set_cand(e, 0, $urandom_range(0, 1000), e + 3);
    env_clear();
    run_scenario("distinct", 1'b0);
    checks++;
    if (lut_wr_cnt !== NE || ptr_wr_cnt !== 0) begin
      errors++;
      $display("FAIL distinct_totals: got %0d/%0d want %0d/0", lut_wr_cnt, ptr_wr_cnt, NE);
    end
  endtask

  task automatic test_fallback();
    clear_board();
    set_cand(0, 0, 10, 5);
    set_cand(1, 0, 3, 5);
    env_clear();
    run_scenario("fallback", 1'b0);
    checks++;
    if (lut_mem[5] !== 16'h0002 || ptr[0] != 1 || ptr[1] != 0) begin
      errors++;
      $display("FAIL fallback_owner: got lut %h ptr %0d/%0d want 0002 1/0", lut_mem[5], ptr[0],
               ptr[1]);
    end
  endtask

  task automatic test_tie();
    clear_board();
    set_cand(0, 0, 7, 9);
    set_cand(1, 0, 7, 9);
    env_clear();
    run_scenario("tie", 1'b0);
    checks++;
    if (lut_mem[9] !== 16'h0000 || ptr[0] != 0 || ptr[1] != 1 || lut_wr_cnt !== 1) begin
      errors++;
      $display("FAIL tie_owner_kept: got lut %h ptr %0d/%0d writes %0d want 0000 0/1 1",
               lut_mem[9], ptr[0], ptr[1], lut_wr_cnt);
    end
  endtask

  task automatic test_threshold();
    clear_board();
    for (int e = 0; e < 3; e++)
      for (int k = 0; k < 3; k++) set_cand(e, k, 4, 12);
    env_clear();
    run_scenario("threshold", 1'b0);
    checks++;
    if (conflict_counter_th !== 1'b1) begin
      errors++;
      $display("FAIL threshold_flag: got %b want 1", conflict_counter_th);
    end
  endtask

  task automatic test_random(int iter);
    int n;
    int e;
    int nc;
    clear_board();
    n = $urandom_range(3, 10);
    for (int k = 0; k < n; k++) begin
      e  = $urandom_range(0, NE - 1);
      nc = $urandom_range(1, 3);
      for (int j = 0; j < nc; j++) set_cand(e, j, $urandom_range(0, 15), $urandom_range(0, 4));
    end
    env_clear();
    run_scenario($sformatf("random%0d", iter), 1'b1);
  endtask

  task automatic test_reset_mid_compare();
    int cyc;
    clear_board();
    set_cand(0, 0, 10, 5);
    set_cand(1, 0, 3, 5);
    env_clear();
    @(negedge clk);
    start_cr = 1'b1;
    @(negedge clk);
    start_cr = 1'b0;
    cyc = 0;
    while (write_to_pointer !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (write_to_pointer !== 1'b1) begin
      errors++;
      $display("FAIL midreset_reach_compare: no compare within 200 cycles");
    end
    #1 reset_N = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (outs() !== RST_VEC) begin
      errors++;
      $display("FAIL midreset_outputs: got %h want %h", outs(), RST_VEC);
    end
    @(negedge clk);
    checks++;
    if (ptr_wr_cnt !== 0 || done_cr !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_commit: got ptr writes %0d done %b want 0 0", ptr_wr_cnt,
               done_cr);
    end
    reset_N = 1'b1;
    env_clear();
    run_scenario("after_midreset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_distinct();
    test_fallback();
    test_tie();
    test_threshold();
    for (int i = 0; i < 5; i++) test_random(i);
    test_reset_mid_compare();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oflow_conflict_resolve_fsm.md
OFLOW_CONFLICT_RESOLVE_FSM -- requirements
Module: oflow_conflict_resolve_fsm

Interface
REQ-001 Parameter MAX_CONFLICTS_TH, default 64: conflict count that aborts resolution.
REQ-002 Parameter NUM_ROWS, default 32: score-board rows scanned (ROW_LEN=5).
REQ-003 Parameter NUM_PES, default 24: PEs per row scanned (PE_LEN=5); SCORE_LEN=10, ID_LEN=11, flag width 1.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset_N  in  1  reset, asynchronous, active-low.
REQ-006 start_cr  in  1  one-cycle pulse starting resolution.
REQ-007 done_cr  out  1  one-cycle pulse at completion.
REQ-008 data_out_lut_for_fsm  in  16  LUT read data, {5'b0, row[4:0], pe[4:0], 1'b0}, valid one cycle after address.
REQ-009 address_lut  out  11  LUT address (= ID).
REQ-010 data_in_lut  out  16  LUT write data, same packing as REQ-008.
REQ-011 we_lut  out  1  LUT write enable and flag-register write enable.
REQ-012 csb  out  1  LUT chip select, active-low.
REQ-013 data_out_flag  in  1  flag for address_flag, combinational.
REQ-014 address_flag  out  11  flag address (= address_lut).
REQ-015 data_in_flag  out  1  flag write data.
REQ-016 score_to_cr  in  10  score at row_sel/pe_sel, combinational.
REQ-017 id_to_cr  in  11  ID at row_sel/pe_sel, combinational.
REQ-018 row_sel  out  5  score-board read row.
REQ-019 pe_sel  out  5  score-board read PE.
REQ-020 row_to_change  out  5  score-board write row.
REQ-021 pe_to_change  out  5  score-board write PE.
REQ-022 data_to_score_board  out  1  write data; 1 = advance to next fallback candidate.
REQ-023 write_to_pointer  out  1  one-cycle pointer-write strobe.
REQ-024 conflict_counter_th  out  1  high when conflict count reached MAX_CONFLICTS_TH; held until next start_cr.

Function
REQ-025 States IDLE, READ, CHECK, COMPARE, NEXT, DONE; start_cr in IDLE -> READ with row=pe=0, conflict count=0, pass_conflict=0; start_cr ignored elsewhere.
REQ-026 READ: row_sel/pe_sel=current entry; register score and ID; address_lut=address_flag=ID, csb=0; score all-ones = empty entry -> NEXT.
REQ-027 CHECK: flag=0 -> we_lut=1, csb=0, data_in_flag=1, data_in_lut=current {row,pe}; -> NEXT.
REQ-028 CHECK: flag=1 and LUT owner equals current {row,pe} -> NEXT, no write; otherwise -> COMPARE with row_sel/pe_sel=owner.
REQ-029 COMPARE: lower score wins; tie -> existing owner wins; loser on row_to_change/pe_to_change, write_to_pointer=1, data_to_score_board=1, one cycle.
REQ-030 COMPARE, current wins: also we_lut=1, data_in_lut=current {row,pe}, data_in_flag=1, same cycle.
REQ-031 Each COMPARE increments conflict count (saturating) and sets pass_conflict.
REQ-032 NEXT: pe++ ; at NUM_PES-1 pe=0, row++; after last entry: pass_conflict=1 -> restart scan at 0,0 with pass_conflict cleared, else DONE.
REQ-033 Count reaches MAX_CONFLICTS_TH -> conflict_counter_th=1, go to DONE after current COMPARE.
REQ-034 DONE: done_cr=1 one cycle -> IDLE.
REQ-035 Outside active cycles: we_lut=0, write_to_pointer=0, csb=1, data_to_score_board=0.

Reset
REQ-036 reset_N low, any time (including mid-scan): state IDLE, counters 0, all outputs 0 except csb=1; no done_cr.

Verification
REQ-037 All 768 entries with distinct IDs -> 768 LUT writes, no write_to_pointer, done_cr after one pass.
REQ-038 (0,0) ID 5 score 10; (0,1) ID 5 score 3 -> pointer write to row 0 PE 0, LUT[5]={0,1}, second pass, done_cr.
REQ-039 Equal scores 7 on same ID at (0,0),(0,1) -> loser (0,1); LUT unchanged.
REQ-040 MAX_CONFLICTS_TH=2, three entries same ID, bench never changes IDs -> conflict_counter_th=1, done_cr pulse.
REQ-041 reset_N low during COMPARE -> outputs at reset values next edge; fresh start_cr completes normally.
